// File: rtl/pattern_gen_pkg.sv
// Shared types and helpers for the pattern generator: FSM states, PRBS7 taps,
// pattern byte selection and an 8-step PRBS7 advance.
package pattern_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PATTERN = 2'd1,
    ST_TAIL    = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  localparam logic [2:0] PRBS_TAP_A        = 3'd6;
  localparam logic [2:0] PRBS_TAP_B        = 3'd5;
  localparam logic [6:0] PRBS_DEFAULT_SEED = 7'h7F;

  typedef struct packed {
    logic [6:0] lfsr;
    logic [7:0] bits;
  } prbs_step_t;

  function automatic logic [7:0] pattern_byte(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      2'd3:    b = word[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Eight LFSR steps; the first generated bit ends up in bit 7 of the byte.
  function automatic prbs_step_t prbs7_advance8(input logic [6:0] state);
    prbs_step_t r;
    logic       fb;
    r.lfsr = state;
    r.bits = 8'h00;
    for (int i = 0; i < 8; i++) begin
      fb     = r.lfsr[PRBS_TAP_A] ^ r.lfsr[PRBS_TAP_B];
      r.lfsr = {r.lfsr[5:0], fb};
      r.bits = {r.bits[6:0], fb};
    end
    return r;
  endfunction

endpackage

// File: rtl/prbs7_byte_gen.sv
// PRBS7 byte source: byte_o always holds the next tail byte, so the consumer
// can take it and request the following one in the same cycle.
module prbs7_byte_gen
  import pattern_gen_pkg::*;
#(
  parameter logic [6:0] SEED = PRBS_DEFAULT_SEED
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic       advance_i,
  output logic [7:0] byte_o
);

  logic [6:0] lfsr_q;
  logic [7:0] byte_q;
  prbs_step_t step_d;

  always_comb begin
    if (load_i) begin
      step_d = prbs7_advance8(SEED);
    end else begin
      step_d = prbs7_advance8(lfsr_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= SEED;
      byte_q <= 8'h00;
    end else if (load_i || advance_i) begin
      lfsr_q <= step_d.lfsr;
      byte_q <= step_d.bits;
    end
  end

  assign byte_o = byte_q;

endmodule

// File: rtl/pattern_generator.sv
// Test-traffic transmitter: (n_repeats+1) copies of a 32-bit pattern, MSB byte
// first, followed by a PRBS7 tail, over a valid/ready byte stream.
module pattern_generator
  import pattern_gen_pkg::*;
#(
  parameter int unsigned TAIL_BYTES = 16,
  parameter logic [6:0]  PRBS_SEED  = PRBS_DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [31:0] pattern_i,
  input  logic [7:0]  n_repeats_i,
  input  logic        data_ready_i,
  output logic [7:0]  data_out_o,
  output logic        data_valid_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam logic [15:0] TAIL_LAST = 16'(TAIL_BYTES - 32'd1);

  state_e      state_q;
  logic [31:0] pattern_q;
  logic [7:0]  n_rep_q;
  logic [1:0]  idx_q;
  logic [8:0]  copy_q;
  logic [15:0] tail_cnt_q;
  logic [7:0]  data_out_q;
  logic        data_valid_q;
  logic        busy_q;
  logic        done_q;

  logic        accept_s;
  logic        start_ok_s;
  logic        last_pat_s;
  logic        last_tail_s;
  logic        prbs_adv_s;
  logic [7:0]  prbs_byte_s;

  assign accept_s    = data_valid_q && data_ready_i;
  assign start_ok_s  = start_i && !abort_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign last_pat_s  = (idx_q == 2'd3) && (copy_q == {1'b0, n_rep_q});
  assign last_tail_s = (tail_cnt_q == TAIL_LAST);
  // The PRBS source steps whenever its current byte moves into data_out.
  assign prbs_adv_s  = accept_s && !abort_i &&
                       (((state_q == ST_PATTERN) && last_pat_s) ||
                        ((state_q == ST_TAIL) && !last_tail_s));

  prbs7_byte_gen #(
    .SEED (PRBS_SEED)
  ) u_prbs (
    .clk       (clk),
    .rst       (rst),
    .load_i    (start_ok_s),
    .advance_i (prbs_adv_s),
    .byte_o    (prbs_byte_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pattern_q    <= 32'h0000_0000;
      n_rep_q      <= 8'h00;
      idx_q        <= 2'd0;
      copy_q       <= 9'd0;
      tail_cnt_q   <= 16'd0;
      data_out_q   <= 8'h00;
      data_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else if (abort_i) begin
      state_q      <= ST_IDLE;
      data_out_q   <= 8'h00;
      data_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            state_q      <= ST_PATTERN;
            pattern_q    <= pattern_i;
            n_rep_q      <= n_repeats_i;
            idx_q        <= 2'd0;
            copy_q       <= 9'd0;
            tail_cnt_q   <= 16'd0;
            data_out_q   <= pattern_byte(pattern_i, 2'd0);
            data_valid_q <= 1'b1;
            busy_q       <= 1'b1;
          end
        end
        ST_PATTERN: begin
          if (accept_s) begin
            idx_q <= idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              copy_q <= copy_q + 9'd1;
            end
            if (!last_pat_s) begin
              data_out_q <= pattern_byte(pattern_q, idx_q + 2'd1);
            end else if (TAIL_BYTES == 32'd0) begin
              state_q      <= ST_DONE;
              data_out_q   <= 8'h00;
              data_valid_q <= 1'b0;
              busy_q       <= 1'b0;
              done_q       <= 1'b1;
            end else begin
              state_q    <= ST_TAIL;
              data_out_q <= prbs_byte_s;
            end
          end
        end
        ST_TAIL: begin
          if (accept_s) begin
            if (last_tail_s) begin
              state_q      <= ST_DONE;
              data_out_q   <= 8'h00;
              data_valid_q <= 1'b0;
              busy_q       <= 1'b0;
              done_q       <= 1'b1;
            end else begin
              tail_cnt_q <= tail_cnt_q + 16'd1;
              data_out_q <= prbs_byte_s;
            end
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          data_valid_q <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign data_out_o   = data_out_q;
  assign data_valid_o = data_valid_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule
